// File: rtl/mini_cpu_pkg.sv
// Shared MiniCPU definitions: bus field layout, default NOP/HALT codes and
// the sequencer state encoding.
package mini_cpu_pkg;

   localparam int WORD_W  = 12;
   localparam int CMD_MSB = 11;
   localparam int CMD_LSB = 8;
   localparam int OPND_W  = 8;

   localparam logic [WORD_W-1:0]      NOP_WORD_DEF = 12'h000;
   localparam logic [CMD_MSB-CMD_LSB:0] HALT_CMD_DEF = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [CMD_MSB-CMD_LSB:0] cmd_of(input logic [WORD_W-1:0] w);
      return w[CMD_MSB:CMD_LSB];
   endfunction

endpackage

// File: rtl/mini_cpu_sequencer_prog_ram.sv
// Program storage: register array, synchronous write, asynchronous read.
// The array is deliberately not reset; validity is tracked by the word count.
module prog_ram
   import mini_cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mini_cpu_sequencer.sv
// Replays a host-loaded program into the MiniCPU IN word, one word per cycle,
// with pause, in-program halt and abort; drives NOP whenever nothing issues.
module mini_cpu_sequencer
   import mini_cpu_pkg::*;
#(
   parameter int                DEPTH    = 16,
   parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF,
   parameter logic [3:0]        HALT_CMD = HALT_CMD_DEF,
   localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LOAD_VALID,
   input  logic [WORD_W-1:0] LOAD_DATA,
   output logic              LOAD_READY,
   input  logic              START,
   input  logic              PAUSE,
   input  logic              CLEAR,
   output logic [WORD_W-1:0] PROG_OUT,
   output logic              ISSUE,
   output logic [AW-1:0]     PC,
   output logic              BUSY,
   output logic              DONE,
   output logic [1:0]        DBG_STATE
);

   // Load handshake: a word transfers on an edge where LOAD_VALID & LOAD_READY.
   // LOAD_READY depends only on registered state (and RST), never on LOAD_VALID.

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t            state_q;
   logic [AW-1:0]     pc_q;
   logic [AW:0]       count_q;
   logic [WORD_W-1:0] prog_out_q;
   logic              issue_q;

   logic              load_fire;
   logic [AW:0]       count_post;
   logic [WORD_W-1:0] rd_data;
   logic              last_word;

   assign LOAD_READY = (state_q == ST_IDLE) && (count_q < DEPTH_C) && !RST;
   // CLEAR wins over a same-cycle load, so the write is suppressed as well.
   assign load_fire  = LOAD_VALID && LOAD_READY && !CLEAR;
   assign count_post = count_q + {{AW{1'b0}}, load_fire};
   assign last_word  = ({1'b0, pc_q} == (count_q - 1'b1));

   prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk_i   (CLK),
      .we_i    (load_fire),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (LOAD_DATA),
      .raddr_i (pc_q),
      .rdata_o (rd_data)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         count_q    <= '0;
         prog_out_q <= NOP_WORD;
         issue_q    <= 1'b0;
      end else if (CLEAR) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         count_q    <= '0;
         prog_out_q <= NOP_WORD;
         issue_q    <= 1'b0;
      end else begin
         prog_out_q <= NOP_WORD;
         issue_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               count_q <= count_post;
               if (START && (count_post != '0)) begin
                  state_q <= ST_RUN;
                  pc_q    <= '0;
               end
            end
            ST_RUN: begin
               if (!PAUSE) begin
                  if (cmd_of(rd_data) == HALT_CMD) begin
                     state_q <= ST_DONE;
                  end else begin
                     prog_out_q <= rd_data;
                     issue_q    <= 1'b1;
                     if (last_word) begin
                        state_q <= ST_DONE;
                     end else begin
                        pc_q <= pc_q + 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (START) begin
                  state_q <= ST_RUN;
                  pc_q    <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign PROG_OUT  = prog_out_q;
   assign ISSUE     = issue_q;
   assign PC        = pc_q;
   assign BUSY      = (state_q == ST_RUN);
   assign DONE      = (state_q == ST_DONE);
   assign DBG_STATE = state_q;

endmodule
